// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM encoding,
// parameter defaults, byte-enable patterns and the latched request record.
package data_mem_ctrl_pkg;

  localparam int DM_DEPTH_DEF   = 1024;
  localparam int DM_LATENCY_DEF = 2;

  // FSM encoding kept as plain constants so older code can compare against it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ByteEn patterns
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Request fields captured when an access is accepted
  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_req_t;

  // A sub-word store that may sit at a non-zero Addr[1:0]: one byte or an aligned halfword
  function automatic logic be_subword_ok(input logic [3:0] be);
    return (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3) ||
           (be == BE_HLO) || (be == BE_HHI);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_dm_array.sv
// Data word storage: one 8-bit lane per byte, synchronous write with
// per-byte enables, asynchronous read, contents untouched by reset.
module dm_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    // Byte lane write, only when this lane is enabled
    always_ff @(posedge Clk) begin
      if (we && be[b]) lane_mem[addr] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller. Each access stalls the pipeline for
// LATENCY+1 cycles (one for errors), then spends a single DONE cycle with
// RValid high and Stall low.
// Optional feature: define DM_BYTE_STORE_EN to honor ByteEn and accept byte
// and aligned-halfword stores at non-zero Addr[1:0]; otherwise every store is
// a full word and any misalignment is an error.
// LATENCY must lie in 1..15 (4-bit counter).
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH   = DM_DEPTH_DEF,
  parameter int LATENCY = DM_LATENCY_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] RData,
  output logic        RValid,
  output logic        Stall,
  output logic        AddrErr
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

  logic [1:0]    state;
  logic [3:0]    cnt;
  dm_req_t       lat;
  logic [AW-1:0] lat_idx;
  logic          req_err;
  logic          commit;
  logic [3:0]    wr_be;
  logic [31:0]   arr_rdata;

  // Error decode on the live request, evaluated while IDLE
  always_comb begin
    req_err = ({1'b0, Addr} >= ADDR_LIMIT);
`ifdef DM_BYTE_STORE_EN
    if (Addr[1:0] != 2'b00 && !(MemWrite && be_subword_ok(ByteEn))) req_err = 1'b1;
`else
    if (Addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

`ifdef DM_BYTE_STORE_EN
  assign wr_be = lat.be;
`else
  // ByteEn is captured but has no effect on writes in this build
  logic unused_be;
  assign unused_be = ^lat.be;
  assign wr_be     = BE_WORD;
`endif

  // Reset gates Stall directly so it drops without waiting for a clock
  assign Stall  = Req & (state != ST_DONE) & ~Reset;
  // Last BUSY cycle: the array is touched on this edge
  assign commit = (state == ST_BUSY) && (cnt <= 4'd1);

  dm_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .Clk   (Clk),
    .we    (commit & lat.we),
    .addr  (lat_idx),
    .wdata (lat.wdata),
    .be    (wr_be),
    .rdata (arr_rdata)
  );

  // FSM, latency counter, request capture and registered response
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      lat     <= '0;
      lat_idx <= '0;
      RData   <= 32'd0;
      RValid  <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          RValid  <= 1'b0;
          AddrErr <= 1'b0;
          RData   <= 32'd0;
          if (Req) begin
            lat.we    <= MemWrite;
            lat.wdata <= WData;
            lat.be    <= ByteEn;
            lat_idx   <= Addr[AW+1:2];
            if (req_err) begin
              // Bad address skips BUSY entirely and never reaches the array
              state   <= ST_DONE;
              RValid  <= 1'b1;
              AddrErr <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= LAT_INIT;
            end
          end
        end
        ST_BUSY: begin
          // Runs to completion even if Req drops (pipeline flush)
          if (cnt <= 4'd1) begin
            state   <= ST_DONE;
            RValid  <= 1'b1;
            AddrErr <= 1'b0;
            RData   <= lat.we ? 32'd0 : arr_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          RValid  <= 1'b0;
          AddrErr <= 1'b0;
          RData   <= 32'd0;
        end
        default: begin
          state   <= ST_IDLE;
          RValid  <= 1'b0;
          AddrErr <= 1'b0;
          RData   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (DEPTH=1024, LATENCY=2): directed
// scenarios followed by randomized accesses against a word-level model.
module tb_data_mem_ctrl;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [3:0]  ByteEn;
  logic [31:0] RData;
  logic        RValid;
  logic        Stall;
  logic        AddrErr;

  int checks   = 0;
  int failures = 0;

  // Reference memory: word index -> contents
  logic [31:0] model [int];

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WData    (WData),
    .ByteEn   (ByteEn),
    .RData    (RData),
    .RValid   (RValid),
    .Stall    (Stall),
    .AddrErr  (AddrErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input bit we, input logic [31:0] a, input logic [3:0] be);
    if (a >= 32'(DEPTH * 4)) return 1'b1;
    if (a[1:0] != 2'b00) begin
`ifdef DM_BYTE_STORE_EN
      return !(we && (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100}));
`else
      return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a);
    int w = int'(a >> 2);
    return model.exists(w) ? model[w] : 32'd0;
  endfunction

  function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int w = int'(a >> 2);
    logic [31:0] v = model.exists(w) ? model[w] : 32'd0;
`ifdef DM_BYTE_STORE_EN
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
`else
    v = d;
`endif
    model[w] = v;
  endfunction

  // Present one request and wait (bounded) for its RValid cycle
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit drop,
                        output logic [31:0] rd, output bit er, output int stalls,
                        output bit dstall, output bit got);
    @(negedge Clk);
    Req = 1'b1; MemWrite = we; Addr = a; WData = d; ByteEn = be;
    stalls = 0; got = 1'b0; rd = 32'd0; er = 1'b0; dstall = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (RValid) begin
        rd = RData; er = AddrErr; dstall = Stall; got = 1'b1;
        break;
      end
      if (Stall) stalls++;
      @(negedge Clk);
      if (drop && n == 0) Req = 1'b0;
    end
    Req = 1'b0;
  endtask

  // One access checked against the model, then the model is updated
  task automatic txn(input string tag, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input bit drop);
    bit          e_err = m_err(we, a, be);
    logic [31:0] e_rd  = (e_err || we) ? 32'd0 : m_load(a);
    int          e_st  = (e_err || drop) ? 1 : LATENCY + 1;
    logic [31:0] rd;
    bit          er, dstall, got;
    int          stalls;
    access(we, a, d, be, drop, rd, er, stalls, dstall, got);
    chk({tag, ".rvalid"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ".err"},    32'(er), 32'(e_err));
      chk({tag, ".rdata"},  rd, e_rd);
      chk({tag, ".stalls"}, 32'(stalls), 32'(e_st));
      chk({tag, ".dstall"}, 32'(dstall), 32'd0);
    end
    @(negedge Clk); #1;
    chk({tag, ".pulse1"}, 32'(RValid), 32'd0);
    if (!e_err && we) m_store(a, d, be);
  endtask

  initial begin
    int          pulses, first_c, second_c;
    logic [31:0] a;
    logic [3:0]  be;
    logic [3:0]  be_tab [8];
    be_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h6};

    Reset = 1'b1; Req = 1'b1; MemWrite = 1'b0; Addr = '0; WData = '0; ByteEn = 4'hF;
    #2;
    chk("rst.rvalid",  32'(RValid),  32'd0);
    chk("rst.addrerr", 32'(AddrErr), 32'd0);
    chk("rst.rdata",   RData,        32'd0);
    chk("rst.stall",   32'(Stall),   32'd0);
    Req = 1'b0;
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;

    // Known contents for words 0..15
    for (int w = 0; w < 16; w++) txn("init", 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);

    // Basic store/load
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    chk("ld10.model", m_load(32'h10), 32'hDEADBEEF);

    // Sub-word store at a misaligned address
    txn("clr10", 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    txn("st11",  1'b1, 32'h11, 32'h0000AA00, 4'b0010, 1'b0);
    txn("ld10b", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
`ifdef DM_BYTE_STORE_EN
    chk("st11.model", m_load(32'h10), 32'h0000AA00);
`else
    chk("st11.model", m_load(32'h10), 32'h0);
`endif

    // Out of range, and range boundaries
    txn("ld1000", 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
    txn("stFFC",  1'b1, 32'hFFC, 32'hA5A5_5A5A, 4'hF, 1'b0);
    txn("ldFFC",  1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0);
    txn("ldTop",  1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0);

    // Flush during BUSY still commits
    txn("st20drop", 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1);
    txn("ld20",     1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

    // Reset in the first BUSY cycle aborts the store
    @(negedge Clk);
    Req = 1'b1; MemWrite = 1'b1; Addr = 32'h30; WData = 32'hFFFF_FFFF; ByteEn = 4'hF;
    @(negedge Clk); #1;
    Reset = 1'b1; #1;
    chk("rstbusy.rvalid",  32'(RValid),  32'd0);
    chk("rstbusy.addrerr", 32'(AddrErr), 32'd0);
    chk("rstbusy.rdata",   RData,        32'd0);
    chk("rstbusy.stall",   32'(Stall),   32'd0);
    #1; Reset = 1'b0; Req = 1'b0;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clk); #1;
      if (RValid) pulses++;
    end
    chk("rstbusy.nopulse", 32'(pulses), 32'd0);
    txn("ld30", 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);

    // Back-to-back loads with Req held
    @(negedge Clk);
    Req = 1'b1; MemWrite = 1'b0; Addr = 32'h4; ByteEn = 4'hF;
    pulses = 0; first_c = -1; second_c = -1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (RValid) begin
        pulses++;
        if (pulses == 1) begin
          first_c = c;
          chk("b2b.rd1", RData, m_load(32'h4));
          Addr = 32'h8;
        end else if (pulses == 2) begin
          second_c = c;
          chk("b2b.rd2", RData, m_load(32'h8));
          Req = 1'b0;
        end
      end
      if (second_c >= 0 && c >= second_c + 4) break;
      @(negedge Clk);
    end
    Req = 1'b0;
    chk("b2b.pulses", 32'(pulses), 32'd2);
    chk("b2b.gap",    32'(second_c - first_c), 32'd4);

    // Randomized accesses
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + ($urandom & 32'h00FF_FFFC);
        1, 2:    a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      be = be_tab[$urandom_range(0, 7)];
      txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, be, ($urandom_range(0, 4) == 0));
    end

    // Final readback of every tracked word
    for (int w = 0; w < 16; w++) txn("final", 1'b0, 32'(w * 4), 32'h0, 4'hF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 32-bit data words.
REQ-002 SHALL have parameter LATENCY, default 2, the number of BUSY cycles per access; legal range 1..15.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Req  input  1  MEM-stage access request, held by the pipeline while Stall=1.
REQ-006 SHALL have port MemWrite  input  1  1=store, 0=load.
REQ-007 SHALL have port Addr  input  32  byte address (the EX/MEM ALU result).
REQ-008 SHALL have port WData  input  32  store data.
REQ-009 SHALL have port ByteEn  input  4  per-byte store enables; ByteEn[0] selects bits 7:0.
REQ-010 SHALL have port RData  output  32  load data, valid while RValid=1.
REQ-011 SHALL have port RValid  output  1  access-complete strobe, high for exactly one cycle.
REQ-012 SHALL have port Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-013 SHALL have port AddrErr  output  1  out-of-range or misaligned access, qualified by RValid.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL drive Stall combinationally as Req AND (state != DONE).
REQ-016 In IDLE with Req=1, SHALL latch MemWrite, Addr, WData and ByteEn, load the counter with LATENCY, and go to BUSY.
REQ-017 In BUSY, SHALL decrement the counter every cycle; when the counter equals 1, SHALL perform the array access and go to DONE.
REQ-018 A legal request SHALL hold Stall high for LATENCY+1 cycles, followed by one DONE cycle with Stall=0 and RValid=1.
REQ-019 DONE SHALL always return to IDLE on the next edge, so a Req presented in that cycle counts as a new request.
REQ-020 A load SHALL return the full word at Addr[31:2] on RData during DONE; a store SHALL leave RData at 0.
REQ-021 A store SHALL write only the bytes whose ByteEn bit is set, subject to REQ-031 and REQ-032.
REQ-022 SHALL flag an error when Addr >= DEPTH*4, or when Addr[1:0] != 0 with an access other than a byte or aligned-halfword store.
REQ-023 On an error, SHALL go IDLE->DONE directly, set AddrErr=1 and RData=0, and SHALL NOT modify the array.
REQ-024 If Req falls while in BUSY (pipeline flush), SHALL still complete the access, including committing any store, and pulse RValid.
REQ-025 The counter SHALL be 4 bits wide and SHALL NOT wrap below 1.
REQ-026 Array contents SHALL persist across back-to-back accesses; a load immediately after a store to the same word SHALL return the new data.

Reset
REQ-027 Reset=1 SHALL force state to IDLE, the counter to 0, RData to 0, RValid to 0 and AddrErr to 0, independent of Clk.
REQ-028 Reset asserted in BUSY before the commit edge SHALL abort the access with no array write.
REQ-029 Reset SHALL NOT clear the array contents.
REQ-030 Stall SHALL be 0 while Reset=1.

Configuration
REQ-031 With macro DM_BYTE_STORE_EN defined, SHALL honor ByteEn and accept byte stores and aligned halfword stores (ByteEn 0011/1100).
REQ-032 Without DM_BYTE_STORE_EN, SHALL ignore ByteEn, treat every store as a full-word store, and flag any Addr[1:0] != 0 as an error.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the DEPTH and LATENCY defaults, and the ByteEn pattern constants.
REQ-034 Storage SHALL be a sub-module dm_array: synchronous write with byte enables, asynchronous read, no reset.
REQ-035 The FSM, counter and error decode SHALL reside in data_mem_ctrl.

Verification
REQ-036 Store Addr=0x10, WData=0xDEADBEEF, ByteEn=1111, LATENCY=2 -> Stall high 3 cycles, then RValid=1 with AddrErr=0; a following load from 0x10 returns 0xDEADBEEF.
REQ-037 With DM_BYTE_STORE_EN defined, store Addr=0x11, WData=0x0000AA00, ByteEn=0010 over a word of 0 -> a following load returns 0x0000AA00; without the macro, the same store -> AddrErr=1 and the word is unchanged.
REQ-038 Load Addr=0x1000 with DEPTH=1024 -> Stall high 1 cycle, then RValid=1, AddrErr=1, RData=0.
REQ-039 Store 0x12345678 to 0x20, then drop Req during BUSY -> RValid pulses, and a later load from 0x20 returns 0x12345678.
REQ-040 Store 0xFFFFFFFF to 0x30 with Reset pulsed during the first BUSY cycle -> state=IDLE, outputs 0, and a later load from 0x30 returns the prior value.
REQ-041 Two back-to-back loads with Req held high -> exactly two RValid pulses, 4 cycles apart at LATENCY=2.
